alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Upstream issue/retire stage wrapped around the 16-bit templatized ALU.
- Accepts {op, A, B} commands on a valid/ready interface and buffers them in a small FIFO.
- Issues at most one command per cycle to the ALU:
  - A/B are presented in the issue cycle, because the ALU registers them.
  - op is presented one cycle later, aligned with the ALU's registered operands, because the ALU decodes op combinationally.
- Captures the single-cycle-valid ALU result into a 2-entry result buffer and returns it on a valid/ready interface.
- The ALU has no stall, so issue is credit-gated against result-buffer space.

Parameters:
- WIDTH, 16, operand/result width.
- OP_WIDTH, 3, opcode width.
- DEPTH, 4, command FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command FIFO not full.
- in_op  input  OP_WIDTH  command opcode.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- alu_a  output  WIDTH  to ALU A (sampled by ALU every edge).
- alu_b  output  WIDTH  to ALU B.
- alu_op  output  OP_WIDTH  to ALU op, registered.
- alu_out  input  WIDTH  ALU result (combinational from ALU registered operands and alu_op).
- res_valid  output  1  result buffer non-empty.
- res_ready  input  1  result consumer ready.
- res_data  output  WIDTH  result at buffer head.
- res_op  output  OP_WIDTH  opcode that produced res_data.

Behaviour:
- Interface decided: one clock, clk; reset is rst_n, asynchronous, active-low.
- Reset state (immediate on rst_n=0):
  - FIFO pointers/count = 0; inflight = 0; result buffer count = 0.
  - alu_op = 0; res_valid = 0; in_ready = 1.
  - res_data/res_op = 0 (buffer storage cleared).
- Command FIFO:
  - push = in_valid && in_ready; in_ready = !full.
  - No push on full, even with simultaneous pop (in_ready does not depend on pop).
  - Simultaneous push+pop on non-full, non-empty: count unchanged.
  - No bypass: an entry pushed at edge e is issuable no earlier than edge e+1.
- Issue:
  - fire = !fifo_empty && (res_count + inflight − (res_valid && res_ready)) < 2. res_ready is a combinational path into fire.
  - alu_a/alu_b = FIFO head A/B when !fifo_empty, else 0. The ALU captures them at the fire edge.
  - On fire:
    - pop the FIFO;
    - alu_op <= head op;
    - op_q <= head op (tag for retire);
    - inflight <= 1.
  - Without fire: inflight <= 0; alu_op holds its last value.
- Retire:
  - In the cycle after a fire edge (inflight=1), alu_out is valid.
  - At that cycle's closing edge, push {alu_out, op_q} into the result buffer.
  - The credit rule guarantees space, so an overflow condition must never occur (assertion).
- Result buffer:
  - 2-entry FIFO; res_valid = count ≠ 0; res_data/res_op = head.
  - Pop on res_valid && res_ready; simultaneous push+pop allowed.
  - Results are returned strictly in command order.
- Latency: command accepted at edge e0 → fire at e1 → captured at e2 → res_valid=1 in the cycle after e2. Minimum 3 cycles from the in_valid cycle.
- Throughput: 1 command/cycle sustained while res_ready=1.
- Backpressure: with res_ready=0, at most 2 results are held; further issue stalls and the FIFO fills, deasserting in_ready.
- Reset mid-operation: all queued, inflight and buffered commands are discarded; no result is produced after rst_n rises.

Test Plan:
- Single command (bench ALU model: op 0 → A+B), in_op=0, in_a=16'h0003, in_b=16'h0004, res_ready=1 → alu_op=0 one cycle after alu_a=3; res_valid=1 for exactly 1 cycle, 3 cycles after in_valid; res_data=16'h0007, res_op=0.
- Back-to-back 8 commands, res_ready=1 → fire every cycle after the first; 8 results in order, consecutive cycles, values match bench model; in_ready never drops.
- res_ready=0, push 8 commands → exactly 2 results buffered; FIFO holds 4; in_ready=0 after 6 accepts. Raise res_ready → all 6 drain in order with no loss or duplication.
- Full FIFO, in_valid=1 while a pop occurs → no push that cycle; in_ready=1 next cycle; the command is accepted then.
- Wrap-around: 3×DEPTH commands with random res_ready toggling → every result matches the model and its order, including across pointer wrap (e.g. A=16'hFFFF, B=1 for op 0 gives 16'h0000).
- Assert rst_n=0 asynchronously with an inflight command and 2 buffered results → res_valid=0 and in_ready=1 immediately; alu_op=0; no res_valid after release until new commands are accepted.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue/retire wrapper for a registered-operand ALU: commands queue in a FIFO, results return in order.
// Command to result takes at least 3 cycles. Issue is credit-gated on the 2-entry result buffer, and in_ready drops only when the command FIFO is full.

module alu_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop_vld,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head_dat
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
    end else begin
      if (i_push_vld) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop_vld) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (i_push_vld && !i_pop_vld)      r_count <= r_count + (AW+1)'(1);
      else if (!i_push_vld && i_pop_vld) r_count <= r_count - (AW+1)'(1);
    end
  end

  assign o_full     = (r_count == (AW+1)'(D));
  assign o_empty    = (r_count == '0);
  assign o_head_dat = r_mem[r_rd_ptr];
endmodule

module alu_issue_stage #(
  parameter int WIDTH    = 16,
  parameter int OP_WIDTH = 3,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] in_op,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OP_WIDTH-1:0] alu_op,
  input  logic [WIDTH-1:0]    alu_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIDTH-1:0]    res_data,
  output logic [OP_WIDTH-1:0] res_op
);
  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
  } cmd_t;

  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [WIDTH-1:0]    data;
  } res_t;

  cmd_t w_cmd_in, w_cmd_head;
  res_t w_res_in, w_res_head;
  logic w_cmd_full, w_cmd_empty, w_cmd_push;
  logic w_res_full, w_res_empty, w_res_pop;
  logic [1:0] w_res_cnt;
  logic [2:0] w_used;
  logic w_fire;

  logic                r_inflight;
  logic [OP_WIDTH-1:0] r_alu_op;

  assign w_cmd_in   = '{op: in_op, a: in_a, b: in_b};
  assign in_ready   = !w_cmd_full;
  assign w_cmd_push = in_valid && !w_cmd_full;

  alu_fifo #(.W($bits(cmd_t)), .D(DEPTH)) u_cmd_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (w_cmd_push),
    .i_push_dat (w_cmd_in),
    .i_pop_vld  (w_fire),
    .o_full     (w_cmd_full),
    .o_empty    (w_cmd_empty),
    .o_head_dat (w_cmd_head)
  );

  // Slots committed to the result buffer after this edge: held, plus in flight, minus the one leaving now.
  assign w_res_pop = !w_res_empty && res_ready;
  assign w_res_cnt = {w_res_full, !w_res_empty && !w_res_full};
  assign w_used    = {1'b0, w_res_cnt} + {2'b0, r_inflight} - {2'b0, w_res_pop};
  assign w_fire    = !w_cmd_empty && (w_used < 3'd2);

  assign alu_a  = w_cmd_empty ? '0 : w_cmd_head.a;
  assign alu_b  = w_cmd_empty ? '0 : w_cmd_head.b;
  assign alu_op = r_alu_op;

  // r_alu_op only changes on fire, so it doubles as the retire tag for the inflight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_alu_op   <= '0;
    end else begin
      r_inflight <= w_fire;
      if (w_fire) r_alu_op <= w_cmd_head.op;
    end
  end

  assign w_res_in = '{op: r_alu_op, data: alu_out};

  alu_fifo #(.W($bits(res_t)), .D(2)) u_res_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (r_inflight),
    .i_push_dat (w_res_in),
    .i_pop_vld  (w_res_pop),
    .o_full     (w_res_full),
    .o_empty    (w_res_empty),
    .o_head_dat (w_res_head)
  );

  assign res_valid = !w_res_empty;
  assign res_data  = w_res_head.data;
  assign res_op    = w_res_head.op;

  a_no_res_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_inflight && w_res_full && !w_res_pop));
endmodule
